exec_unit: RTL and testbench

- Consumer end of the instruction-fetch interface in the 4-bit TD4-style CPU.
- Takes the 8-bit instruction word from fetch and executes it: A/B register file, carry flag, output port, input port.
- Drives the jump target and jump request back to fetch, which selects the next PC from them in the same cycle.

---
 rtl/exec_unit_pkg.sv | 61 ++++++
 rtl/exec_unit_if.sv | 12 +
 rtl/exec_unit_alu4.sv | 13 +
 rtl/exec_unit.sv | 68 ++++++
 tb/tb_exec_unit.sv | 136 +++++++++++++
 5 files changed

// File: rtl/exec_unit_pkg.sv
// Shared definitions for the TD4-style execute stage: opcode values, datapath
// width, immediate field position and the opcode decoder used by exec_unit.
package exec_unit_pkg;

  localparam int DW     = 4;
  localparam int IM_LSB = 0;
  localparam int IM_MSB = 3;

  typedef enum logic [3:0] {
    OP_ADD_A  = 4'b0000,
    OP_MOV_AB = 4'b0001,
    OP_IN_A   = 4'b0010,
    OP_MOV_AI = 4'b0011,
    OP_MOV_BA = 4'b0100,
    OP_ADD_B  = 4'b0101,
    OP_IN_B   = 4'b0110,
    OP_MOV_BI = 4'b0111,
    OP_OUT_B  = 4'b1001,
    OP_OUT_I  = 4'b1011,
    OP_JNC    = 4'b1110,
    OP_JMP    = 4'b1111
  } opcode_t;

  typedef enum logic [1:0] {
    SRC_A    = 2'd0,
    SRC_B    = 2'd1,
    SRC_IN   = 2'd2,
    SRC_ZERO = 2'd3
  } src_t;

  typedef struct packed {
    logic wr_a;
    logic wr_b;
    logic wr_out;
    logic use_imm;
    logic carry_en;
    src_t src;
  } ctrl_t;

  // Every instruction is "dest <= src + (use_imm ? Im : 0)"; only ADDs keep cout.
  function automatic ctrl_t decode(input logic [3:0] op);
    ctrl_t c;
    c = '{wr_a: 1'b0, wr_b: 1'b0, wr_out: 1'b0, use_imm: 1'b0,
          carry_en: 1'b0, src: SRC_ZERO};
    case (op)
      OP_ADD_A:  begin c.wr_a = 1'b1;   c.src = SRC_A;    c.use_imm = 1'b1; c.carry_en = 1'b1; end
      OP_MOV_AB: begin c.wr_a = 1'b1;   c.src = SRC_B;    end
      OP_IN_A:   begin c.wr_a = 1'b1;   c.src = SRC_IN;   end
      OP_MOV_AI: begin c.wr_a = 1'b1;   c.src = SRC_ZERO; c.use_imm = 1'b1; end
      OP_MOV_BA: begin c.wr_b = 1'b1;   c.src = SRC_A;    end
      OP_ADD_B:  begin c.wr_b = 1'b1;   c.src = SRC_B;    c.use_imm = 1'b1; c.carry_en = 1'b1; end
      OP_IN_B:   begin c.wr_b = 1'b1;   c.src = SRC_IN;   end
      OP_MOV_BI: begin c.wr_b = 1'b1;   c.src = SRC_ZERO; c.use_imm = 1'b1; end
      OP_OUT_B:  begin c.wr_out = 1'b1; c.src = SRC_B;    end
      OP_OUT_I:  begin c.wr_out = 1'b1; c.src = SRC_ZERO; c.use_imm = 1'b1; end
      default:   ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/exec_unit_if.sv
// Fetch <-> execute link: instruction word forward, jump request/target back.
interface exec_unit_if;
  import exec_unit_pkg::*;

  logic [7:0]    inst;
  logic          isjump;
  logic [DW-1:0] jumpadrs;

  modport master (output inst, input isjump, input jumpadrs);
  modport slave  (input inst, output isjump, output jumpadrs);

endinterface

// File: rtl/exec_unit_alu4.sv
// Combinational 4-bit adder producing the destination value and carry-out.
module alu4
  import exec_unit_pkg::*;
(
  input  logic [DW-1:0] src,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] sum,
  output logic          cout
);

  assign {cout, sum} = {1'b0, src} + {1'b0, imm};

endmodule

// File: rtl/exec_unit.sv
// Execute stage of the TD4-style CPU: decodes the fetched instruction, updates
// A/B/out_port/carry each cycle and returns the jump request to fetch.
module exec_unit
  import exec_unit_pkg::*;
#(
  parameter int DW = exec_unit_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  exec_unit_if.slave    bus,
  input  logic [DW-1:0] in_port,
  output logic [DW-1:0] out_port,
  output logic [DW-1:0] reg_a,
  output logic [DW-1:0] reg_b,
  output logic          carry
);

  logic [3:0]    opcode;
  logic [DW-1:0] im;
  ctrl_t         ctrl;
  logic [DW-1:0] src_val;
  logic [DW-1:0] addend;
  logic [DW-1:0] sum;
  logic          cout;

  assign opcode = bus.inst[7:4];
  assign im     = bus.inst[IM_MSB:IM_LSB];
  assign ctrl   = decode(opcode);

  always_comb begin
    src_val = '0;
    case (ctrl.src)
      SRC_A:    src_val = reg_a;
      SRC_B:    src_val = reg_b;
      SRC_IN:   src_val = in_port;
      SRC_ZERO: src_val = '0;
      default:  src_val = '0;
    endcase
  end

  assign addend = ctrl.use_imm ? im : '0;

  alu4 u_alu (
    .src  (src_val),
    .imm  (addend),
    .sum  (sum),
    .cout (cout)
  );

  // JNC looks at the carry left by the previous instruction only.
  assign bus.isjump   = (opcode == OP_JMP) || ((opcode == OP_JNC) && !carry);
  assign bus.jumpadrs = im;

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_a    <= '0;
      reg_b    <= '0;
      out_port <= '0;
      carry    <= 1'b0;
    end else begin
      if (ctrl.wr_a)   reg_a    <= sum;
      if (ctrl.wr_b)   reg_b    <= sum;
      if (ctrl.wr_out) out_port <= sum;
      carry <= ctrl.carry_en & cout;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed, table-driven check of exec_unit against hand-computed expectations.
module tb_exec_unit;
  import exec_unit_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] in_port;
  logic [3:0] out_port;
  logic [3:0] reg_a;
  logic [3:0] reg_b;
  logic       carry;

  exec_unit_if bus ();

  exec_unit dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .in_port  (in_port),
    .out_port (out_port),
    .reg_a    (reg_a),
    .reg_b    (reg_b),
    .carry    (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [7:0] inst;
    logic [3:0] in_port;
    logic       exp_isjump;
    logic [3:0] exp_jadrs;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
    logic [3:0] exp_out;
    logic       exp_carry;
  } vec_t;

  int tests  = 0;
  int errors = 0;
  vec_t vecs[$];

  function automatic vec_t mk(string n, logic r, logic [7:0] i, logic [3:0] inp,
                              logic ij, logic [3:0] ja, logic [3:0] a,
                              logic [3:0] b, logic [3:0] o, logic c);
    vec_t v;
    v.name = n; v.rst = r; v.inst = i; v.in_port = inp;
    v.exp_isjump = ij; v.exp_jadrs = ja;
    v.exp_a = a; v.exp_b = b; v.exp_out = o; v.exp_carry = c;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    tests++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; jump outputs are checked
  // before the next edge, register outputs 1 unit after it.
  task automatic applyStimulus(input vec_t v);
    rst      = v.rst;
    bus.inst = v.inst;
    in_port  = v.in_port;
    #1;
    checkOutput({v.name, ".isjump"},   {7'd0, bus.isjump},   {7'd0, v.exp_isjump});
    checkOutput({v.name, ".jumpadrs"}, {4'd0, bus.jumpadrs}, {4'd0, v.exp_jadrs});
    @(posedge clk);
    #1;
    checkOutput({v.name, ".reg_a"},    {4'd0, reg_a},        {4'd0, v.exp_a});
    checkOutput({v.name, ".reg_b"},    {4'd0, reg_b},        {4'd0, v.exp_b});
    checkOutput({v.name, ".out_port"}, {4'd0, out_port},     {4'd0, v.exp_out});
    checkOutput({v.name, ".carry"},    {7'd0, carry},        {7'd0, v.exp_carry});
  endtask

  initial begin
    //               name        rst inst   in    ij  ja     A      B      out    c
    vecs.push_back(mk("rst0",     1, 8'h35, 4'h0, 0, 4'h5, 4'h0, 4'h0, 4'h0, 0));
    vecs.push_back(mk("rst1",     1, 8'h35, 4'h0, 0, 4'h5, 4'h0, 4'h0, 4'h0, 0));
    vecs.push_back(mk("movai5",   0, 8'h35, 4'h0, 0, 4'h5, 4'h5, 4'h0, 4'h0, 0));
    vecs.push_back(mk("movba",    0, 8'h40, 4'h0, 0, 4'h0, 4'h5, 4'h5, 4'h0, 0));
    vecs.push_back(mk("movbiA",   0, 8'h7A, 4'h0, 0, 4'hA, 4'h5, 4'hA, 4'h0, 0));
    vecs.push_back(mk("movab",    0, 8'h10, 4'h0, 0, 4'h0, 4'hA, 4'hA, 4'h0, 0));
    vecs.push_back(mk("movaiF",   0, 8'h3F, 4'h0, 0, 4'hF, 4'hF, 4'hA, 4'h0, 0));
    vecs.push_back(mk("adda_wrap",0, 8'h01, 4'h0, 0, 4'h1, 4'h0, 4'hA, 4'h0, 1));
    vecs.push_back(mk("jnc_c1",   0, 8'hE7, 4'h0, 0, 4'h7, 4'h0, 4'hA, 4'h0, 0));
    vecs.push_back(mk("jnc_c0",   0, 8'hE7, 4'h0, 1, 4'h7, 4'h0, 4'hA, 4'h0, 0));
    vecs.push_back(mk("jmp",      0, 8'hF3, 4'h0, 1, 4'h3, 4'h0, 4'hA, 4'h0, 0));
    vecs.push_back(mk("nop8",     0, 8'h8C, 4'h0, 0, 4'hC, 4'h0, 4'hA, 4'h0, 0));
    vecs.push_back(mk("inb",      0, 8'h60, 4'h9, 0, 4'h0, 4'h0, 4'h9, 4'h0, 0));
    vecs.push_back(mk("outb",     0, 8'h90, 4'h0, 0, 4'h0, 4'h0, 4'h9, 4'h9, 0));
    vecs.push_back(mk("outi",     0, 8'hB6, 4'h0, 0, 4'h6, 4'h0, 4'h9, 4'h6, 0));
    vecs.push_back(mk("ina",      0, 8'h20, 4'h3, 0, 4'h0, 4'h3, 4'h9, 4'h6, 0));
    vecs.push_back(mk("adda_C",   0, 8'h0C, 4'h0, 0, 4'hC, 4'hF, 4'h9, 4'h6, 0));
    vecs.push_back(mk("adda_0",   0, 8'h00, 4'h0, 0, 4'h0, 4'hF, 4'h9, 4'h6, 0));
    vecs.push_back(mk("adda_1",   0, 8'h01, 4'h0, 0, 4'h1, 4'h0, 4'h9, 4'h6, 1));
    vecs.push_back(mk("nopD",     0, 8'hD5, 4'h0, 0, 4'h5, 4'h0, 4'h9, 4'h6, 0));
    vecs.push_back(mk("adda_3",   0, 8'h03, 4'h0, 0, 4'h3, 4'h3, 4'h9, 4'h6, 0));
    vecs.push_back(mk("nopA",     0, 8'hA4, 4'h0, 0, 4'h4, 4'h3, 4'h9, 4'h6, 0));
    vecs.push_back(mk("addb_C",   0, 8'h5C, 4'h0, 0, 4'hC, 4'h3, 4'h5, 4'h6, 1));
    vecs.push_back(mk("rst_mid",  1, 8'h7F, 4'h0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 0));
    vecs.push_back(mk("jnc_post", 0, 8'hE2, 4'h0, 1, 4'h2, 4'h0, 4'h0, 4'h0, 0));
    vecs.push_back(mk("nopC",     0, 8'hC1, 4'hF, 0, 4'h1, 4'h0, 4'h0, 4'h0, 0));

    rst      = 1'b1;
    bus.inst = 8'h00;
    in_port  = 4'h0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Back-to-back moves must act sequentially: A ends up with the new B.
    applyStimulus(mk("seq_a7",  0, 8'h37, 4'h0, 0, 4'h7, 4'h7, 4'h0, 4'h0, 0));
    applyStimulus(mk("seq_b2",  0, 8'h72, 4'h0, 0, 4'h2, 4'h7, 4'h2, 4'h0, 0));
    applyStimulus(mk("seq_ba",  0, 8'h40, 4'h0, 0, 4'h0, 4'h7, 4'h7, 4'h0, 0));
    applyStimulus(mk("seq_ab",  0, 8'h10, 4'h0, 0, 4'h0, 4'h7, 4'h7, 4'h0, 0));

    // Carry from ADD B, then a two-cycle reset carrying loads that must be dropped.
    applyStimulus(mk("seq_bF",  0, 8'h7F, 4'h0, 0, 4'hF, 4'h7, 4'hF, 4'h0, 0));
    applyStimulus(mk("seq_ab2", 0, 8'h52, 4'h0, 0, 4'h2, 4'h7, 4'h1, 4'h0, 1));
    applyStimulus(mk("seq_r0",  1, 8'h3E, 4'h0, 0, 4'hE, 4'h0, 4'h0, 4'h0, 0));
    applyStimulus(mk("seq_r1",  1, 8'hB9, 4'h0, 0, 4'h9, 4'h0, 4'h0, 4'h0, 0));
    applyStimulus(mk("seq_jnc", 0, 8'hE9, 4'h0, 1, 4'h9, 4'h0, 4'h0, 4'h0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
